// File: rtl/count_seq_pkg.sv
// Shared types and default widths for the count sequencer slice.
// Optional pacing is enabled with COUNT_SEQ_PRESCALE_EN.
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  localparam int N_DEF  = 16;
  localparam int P_DEF  = 8;
  localparam int RW_DEF = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Paces counter increments: ticks when the count reaches limit, then restarts from zero.
// Only present when COUNT_SEQ_PRESCALE_EN is defined.
`ifdef COUNT_SEQ_PRESCALE_EN
module tick_prescaler
  import count_seq_pkg::*;
#(
  parameter int P = P_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [P-1:0] limit,
  output logic         tick
);

  logic [P-1:0] count;

  assign tick = (count == limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + P'(1);
    end
  end

endmodule
`endif

// File: rtl/count_sequencer.sv
// Drives a loadable up-counter from start to end per command, in one-shot or auto-reload mode.
// COUNT_SEQ_PRESCALE_EN adds cmd_prescale and the tick_prescaler pacing stage.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int P  = P_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [N-1:0]  cmd_start,
  input  logic [N-1:0]  cmd_end,
  input  logic          cmd_mode,
`ifdef COUNT_SEQ_PRESCALE_EN
  input  logic [P-1:0]  cmd_prescale,
`endif
  input  logic          abort,
  output logic          cnt_load,
  output logic          cnt_inc,
  output logic [N-1:0]  cnt_d,
  input  logic [N-1:0]  cnt_q,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] reload_cnt
);

  state_t        state;
  logic [N-1:0]  start_q;
  logic [N-1:0]  end_q;
  logic          mode_q;
  logic [RW-1:0] reload_q;
  logic          at_end;
  logic          pre_tick;
  logic          accept;

  assign at_end = (cnt_q == end_q);
  assign accept = cmd_valid && cmd_ready && !abort;

`ifdef COUNT_SEQ_PRESCALE_EN
  logic [P-1:0] prescale_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale_q <= '0;
    end else if (accept) begin
      prescale_q <= cmd_prescale;
    end
  end

  tick_prescaler #(.P(P)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == LOAD),
    .enable ((state == RUN) && !at_end),
    .limit  (prescale_q),
    .tick   (pre_tick)
  );
`else
  // Without pacing the limit is fixed at zero, so every eligible RUN cycle ticks.
  localparam logic [P-1:0] PRESCALE_FIXED = '0;
  assign pre_tick = (PRESCALE_FIXED == '0);
`endif

  // Abort wins over every transition, including accept and the DONE exit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      start_q  <= '0;
      end_q    <= '0;
      mode_q   <= MODE_ONESHOT;
      reload_q <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            start_q  <= cmd_start;
            end_q    <= cmd_end;
            mode_q   <= cmd_mode;
            reload_q <= '0;
            state    <= LOAD;
          end
        end
        LOAD: state <= RUN;
        RUN: begin
          if (at_end) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (reload_q != {RW{1'b1}}) begin
            reload_q <= reload_q + RW'(1);
          end
          state <= (mode_q == MODE_RELOAD) ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are decoded so that abort can silence them in the same cycle.
  assign cmd_ready  = (state == IDLE) && reset;
  assign busy       = (state != IDLE);
  assign cnt_load   = (state == LOAD) && !abort;
  assign cnt_inc    = (state == RUN) && !at_end && pre_tick && !abort;
  assign done       = (state == DONE) && !abort;
  assign cnt_d      = start_q;
  assign reload_cnt = reload_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed plus randomized bench for count_sequencer driving a behavioural up-counter.
// Timing expectations come from the command arithmetic: k incs, done in cycle k*(prescale+1)+3.
module tb_count_sequencer;
  import count_seq_pkg::*;

  localparam int N  = 16;
  localparam int P  = 8;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_mode = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  cmd_start = '0;
  logic [N-1:0]  cmd_end = '0;
`ifdef COUNT_SEQ_PRESCALE_EN
  logic [P-1:0]  cmd_prescale = '0;
`endif
  logic          cmd_ready;
  logic          cnt_load;
  logic          cnt_inc;
  logic          busy;
  logic          done;
  logic [N-1:0]  cnt_d;
  logic [N-1:0]  cnt_q;
  logic [RW-1:0] reload_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  count_sequencer #(.N(N), .P(P), .RW(RW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_end    (cmd_end),
    .cmd_mode   (cmd_mode),
`ifdef COUNT_SEQ_PRESCALE_EN
    .cmd_prescale (cmd_prescale),
`endif
    .abort      (abort),
    .cnt_load   (cnt_load),
    .cnt_inc    (cnt_inc),
    .cnt_d      (cnt_d),
    .cnt_q      (cnt_q),
    .busy       (busy),
    .done       (done),
    .reload_cnt (reload_cnt)
  );

  // Shared counter datapath: load beats inc, wraps naturally at 2^N.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cnt_load) begin
      cnt_q <= cnt_d;
    end else if (cnt_inc) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one command and follows it for the given iterations, optionally aborting
  // in cycle abortAt (>=2) of the last iteration; poke offers junk commands while busy.
  task automatic applyStimulus(input string name, input logic [N-1:0] s, input logic [N-1:0] e,
                               input logic m, input int p, input int iters, input int abortAt,
                               input bit poke);
    logic [N-1:0] diff;
    logic [N-1:0] eq;
    logic [2:0]   es;
    int k, pe, t, expReload;
    bit stop, incExp, abortNow;
    diff = e - s;
    k = int'(diff);
`ifdef COUNT_SEQ_PRESCALE_EN
    pe = p;
    cmd_prescale = P'(p);
`else
    pe = 0;
    if (p < 0) pe = 0;
`endif
    t = k * (pe + 1) + 3;
    cmd_start = s;
    cmd_end   = e;
    cmd_mode  = m;
    cmd_valid = 1'b1;
    abort     = 1'b0;
    #1;
    checkOutput({name, ".ready"}, 32'(cmd_ready), 32'd1);
    eq = s;
    stop = 1'b0;
    for (int it = 0; it < iters && !stop; it++) begin
      for (int c = 1; c <= t && !stop; c++) begin
        @(posedge clk);
        #2;
        abortNow  = (it == iters - 1) && (c == abortAt);
        abort     = abortNow;
        cmd_valid = poke && (c == 2);
        if (poke) begin
          cmd_start = N'($urandom);
          cmd_end   = N'($urandom);
          cmd_mode  = MODE_ONESHOT;
        end
        #1;
        incExp = (c >= 2) && (c <= t - 2) && (((c - 1) % (pe + 1)) == 0);
        es = abortNow ? 3'b000 : {c == 1, incExp, c == t};
        checkOutput({name, ".strobes"}, 32'({cnt_load, cnt_inc, done}), 32'(es));
        checkOutput({name, ".busy"}, 32'(busy), 32'd1);
        checkOutput({name, ".readyBusy"}, 32'(cmd_ready), 32'd0);
        if (c == 1) begin
          eq = s;
          checkOutput({name, ".reloadIter"}, 32'(reload_cnt), 32'(sat(it)));
        end else begin
          checkOutput({name, ".q"}, 32'(cnt_q), 32'(eq));
        end
        if (incExp && !abortNow) eq = eq + 16'd1;
        if (abortNow) stop = 1'b1;
      end
    end
    @(posedge clk);
    #2;
    abort = 1'b0;
    cmd_valid = 1'b0;
    #1;
    expReload = stop ? sat(iters - 1) : sat(iters);
    checkOutput({name, ".idleBusy"}, 32'(busy), 32'd0);
    checkOutput({name, ".idleReady"}, 32'(cmd_ready), 32'd1);
    checkOutput({name, ".idleStrobes"}, 32'({cnt_load, cnt_inc, done}), 32'd0);
    checkOutput({name, ".finalQ"}, 32'(cnt_q), stop ? 32'(eq) : 32'(e));
    checkOutput({name, ".reload"}, 32'(reload_cnt), 32'(expReload));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [N-1:0] rs;
    int rk;
    reset = 1'b0;
    #3;
    checkOutput("reset.strobes", 32'({cnt_load, cnt_inc, done}), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.ready", 32'(cmd_ready), 32'd0);
    checkOutput("reset.cntD", 32'(cnt_d), 32'd0);
    checkOutput("reset.reload", 32'(reload_cnt), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("release.ready", 32'(cmd_ready), 32'd1);

    applyStimulus("oneshot", 16'h1234, 16'h1238, MODE_ONESHOT, 0, 1, 0, 1'b0);
    applyStimulus("wrap", 16'hFFFE, 16'h0001, MODE_ONESHOT, 0, 1, 0, 1'b0);
    applyStimulus("prescale", 16'h5678, 16'h567A, MODE_ONESHOT, 3, 1, 0, 1'b0);
    applyStimulus("reload", 16'h0000, 16'h0002, MODE_RELOAD, 0, 4, 3, 1'b1);
    applyStimulus("abortRun", 16'h0100, 16'h0110, MODE_ONESHOT, 1, 1, 6, 1'b0);
    applyStimulus("abortDone", 16'h0200, 16'h0203, MODE_ONESHOT, 0, 1, 6, 1'b0);
    applyStimulus("afterAbort", 16'h0300, 16'h0302, MODE_ONESHOT, 0, 1, 0, 1'b0);

    // Abort in IDLE blocks the accept.
    cmd_start = 16'h0AAA;
    cmd_end   = 16'h0AAC;
    cmd_valid = 1'b1;
    abort     = 1'b1;
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    #1;
    checkOutput("idleAbort.busy", 32'(busy), 32'd0);
    checkOutput("idleAbort.load", 32'(cnt_load), 32'd0);

    // Reset asserted in the middle of RUN.
    cmd_start = 16'h0400;
    cmd_end   = 16'h0420;
    cmd_mode  = MODE_ONESHOT;
    cmd_valid = 1'b1;
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midReset.strobes", 32'({cnt_load, cnt_inc, done}), 32'd0);
    checkOutput("midReset.busy", 32'(busy), 32'd0);
    checkOutput("midReset.ready", 32'(cmd_ready), 32'd0);
    checkOutput("midReset.cntD", 32'(cnt_d), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midReset.readyAfter", 32'(cmd_ready), 32'd1);
    applyStimulus("startEqEnd", 16'h0555, 16'h0555, MODE_ONESHOT, 2, 1, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      rs = N'($urandom);
      rk = int'($urandom_range(0, 12));
      applyStimulus("rand", rs, rs + N'(rk), MODE_ONESHOT, int'($urandom_range(0, 3)), 1, 0, 1'b0);
    end
    rs = N'($urandom);
    applyStimulus("randReload", rs, rs + N'(3), MODE_RELOAD, int'($urandom_range(0, 2)), 2,
                  2 + int'($urandom_range(0, 1)), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
